alu_arbiter: RTL

- Shares one `alu` instance between two requesters (e.g. address unit and execute unit).
- Each requester issues {op, a, b, cin} over a valid/ready handshake. A round-robin arbiter picks one request per cycle and feeds it through a 2-stage pipeline: operand register, then the ALU, then a result register.
- Results return on a single tagged response channel with backpressure.

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu.sv | 57 +++++
 rtl/alu_arbiter_rr_arb2.sv | 28 ++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for alu_arbiter: ALU op codes, flag bit positions and flag packing.
package alu_arbiter_pkg;

  localparam int unsigned AluOpW = 7;
  localparam int unsigned FlagsW = 4;

  localparam int unsigned FlagCout = 0;
  localparam int unsigned FlagZero = 1;
  localparam int unsigned FlagSign = 2;
  localparam int unsigned FlagOvf  = 3;

  localparam logic [AluOpW-1:0] AluAdd  = 7'h00;
  localparam logic [AluOpW-1:0] AluSub  = 7'h01;
  localparam logic [AluOpW-1:0] AluAnd  = 7'h02;
  localparam logic [AluOpW-1:0] AluOr   = 7'h03;
  localparam logic [AluOpW-1:0] AluXor  = 7'h04;
  localparam logic [AluOpW-1:0] AluLsl  = 7'h05;
  localparam logic [AluOpW-1:0] AluLsr  = 7'h06;
  localparam logic [AluOpW-1:0] AluSmul = 7'h07;

  function automatic logic [FlagsW-1:0] pack_flags(input logic cout, input logic zero,
                                                   input logic sign, input logic ovf);
    logic [FlagsW-1:0] f;
    f           = '0;
    f[FlagCout] = cout;
    f[FlagZero] = zero;
    f[FlagSign] = sign;
    f[FlagOvf]  = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU; SUB reports borrow on cout, SMUL keeps the low N bits.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned OpW = AluOpW
) (
  input  logic [OpW-1:0] op_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  input  logic           cin_i,
  output logic [N-1:0]   out_o,
  output logic           cout_o,
  output logic           zero_o,
  output logic           sign_o,
  output logic           overflow_o
);

  logic [N:0]     sum;
  logic [2*N-1:0] prod;

  always_comb begin
    sum        = '0;
    prod       = '0;
    out_o      = '0;
    cout_o     = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      AluAdd: begin
        sum        = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
        out_o      = sum[N-1:0];
        cout_o     = sum[N];
        overflow_o = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      AluSub: begin
        sum        = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, cin_i};
        out_o      = sum[N-1:0];
        cout_o     = sum[N];
        overflow_o = (a_i[N-1] != b_i[N-1]) && (sum[N-1] != a_i[N-1]);
      end
      AluAnd: out_o = a_i & b_i;
      AluOr:  out_o = a_i | b_i;
      AluXor: out_o = a_i ^ b_i;
      AluLsl: out_o = a_i << b_i;
      AluLsr: out_o = a_i >> b_i;
      AluSmul: begin
        prod       = $signed({{N{a_i[N-1]}}, a_i}) * $signed({{N{b_i[N-1]}}, b_i});
        out_o      = prod[N-1:0];
        overflow_o = prod[2*N-1:N] != {N{prod[N-1]}};
      end
      default: out_o = '0;
    endcase
    zero_o = (out_o == '0);
    sign_o = out_o[N-1];
  end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant; last_grant moves only when a granted request is accepted.
module alu_rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic accept_i,
  output logic grant0_o,
  output logic grant1_o
);

  logic last_grant_q;

  always_comb begin
    grant0_o = valid0_i & (~valid1_i | last_grant_q);
    grant1_o = valid1_i & (~valid0_i | ~last_grant_q);
  end

  // Resetting to 1 lets requester 0 win the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
    end else if (accept_i && (grant0_o || grant1_o)) begin
      last_grant_q <= grant1_o;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a 2-stage pipeline with a tagged response channel.
// Define ALU_ARB_CARRY_CHAIN_EN for per-requester carry chaining (use_carry inputs).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned OP_W = AluOpW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [N-1:0]      req0_a,
  input  logic [N-1:0]      req0_b,
  input  logic              req0_cin,
`ifdef ALU_ARB_CARRY_CHAIN_EN
  input  logic              req0_use_carry,
  input  logic              req1_use_carry,
`endif
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [N-1:0]      req1_a,
  input  logic [N-1:0]      req1_b,
  input  logic              req1_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [N-1:0]      rsp_out,
  output logic [FlagsW-1:0] rsp_flags
);

  logic            s1_valid_q, s2_valid_q;
  logic            s1_adv, s2_adv, accept, take;
  logic            grant0, grant1;
  logic [OP_W-1:0] s1_op_q;
  logic [N-1:0]    s1_a_q, s1_b_q;
  logic            s1_cin_q, s1_id_q;
  logic [N-1:0]    alu_out;
  logic            alu_cin, alu_cout, alu_zero, alu_sign, alu_ovf;

  always_comb begin
    s2_adv     = ~s2_valid_q | rsp_ready;
    s1_adv     = s1_valid_q & s2_adv;
    accept     = ~s1_valid_q | s2_adv;
    take       = accept & (grant0 | grant1);
    req0_ready = rst_n & accept & grant0;
    req1_ready = rst_n & accept & grant1;
    rsp_valid  = s2_valid_q;
  end

  alu_rr_arb2 u_arb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .accept_i (accept),
    .grant0_o (grant0),
    .grant1_o (grant1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_id_q    <= 1'b0;
    end else if (take) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= grant1 ? req1_op  : req0_op;
      s1_a_q     <= grant1 ? req1_a   : req0_a;
      s1_b_q     <= grant1 ? req1_b   : req0_b;
      s1_cin_q   <= grant1 ? req1_cin : req0_cin;
      s1_id_q    <= grant1;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

`ifdef ALU_ARB_CARRY_CHAIN_EN
  logic       s1_use_carry_q;
  logic [1:0] carry_q;

  // The previous op of the same id has always left s1, so carry_q is already current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_use_carry_q <= 1'b0;
      carry_q        <= '0;
    end else begin
      if (take) begin
        s1_use_carry_q <= grant1 ? req1_use_carry : req0_use_carry;
      end
      if (s1_adv) begin
        carry_q[s1_id_q] <= alu_cout;
      end
    end
  end

  always_comb alu_cin = s1_use_carry_q ? carry_q[s1_id_q] : s1_cin_q;
`else
  always_comb alu_cin = s1_cin_q;
`endif

  alu #(
    .N   (N),
    .OpW (OP_W)
  ) u_alu (
    .op_i       (s1_op_q),
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .cin_i      (alu_cin),
    .out_o      (alu_out),
    .cout_o     (alu_cout),
    .zero_o     (alu_zero),
    .sign_o     (alu_sign),
    .overflow_o (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= '0;
      rsp_flags  <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      rsp_id     <= s1_id_q;
      rsp_out    <= alu_out;
      rsp_flags  <= pack_flags(alu_cout, alu_zero, alu_sign, alu_ovf);
    end else if (rsp_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

endmodule
